// File: rtl/lfsr_bcd_gen.sv
// Pseudo-random source: Fibonacci LFSR advanced by a synchronised key edge or a
// free-running prescaler, with a sequential double-dabble BCD converter behind it.
module lfsr_bcd_gen #(
  parameter int unsigned WIDTH  = 7,
  parameter int unsigned TAPS   = 'b1100000,
  parameter int unsigned SEED   = 1,
  parameter int unsigned DIGITS = 5,
  parameter int unsigned RATE   = 25000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  step,
  input  logic                  run,
  input  logic                  load,
  input  logic [WIDTH-1:0]      seed_in,
  output logic [WIDTH-1:0]      lfsr_q,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid,
  output logic                  busy
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned PW = $clog2(RATE);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] TAP_MASK = WIDTH'(TAPS);
  localparam logic [WIDTH-1:0] SEED_W   = WIDTH'(SEED);
  localparam logic [PW-1:0]    PRE_LAST = PW'(RATE - 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic             sync1_q, sync2_q, prev_q;
  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] lfsr_d;
  logic             pending_q, pending_d;
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    scratch_q, scratch_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             bcd_valid_q, bcd_valid_d;
  logic             busy_q, busy_d;
  logic             step_evt;
  logic             fb;
  logic [BW-1:0]    adj;

  // Event source: prescaler wrap in free-run, otherwise rising edge of the synchronised key.
  always_comb begin
    step_evt = run ? (pre_q == PRE_LAST) : (sync2_q & ~prev_q);
    pre_d    = (run && (pre_q != PRE_LAST)) ? pre_q + 1'b1 : '0;
  end

  always_comb begin
    fb     = ^(lfsr_q & TAP_MASK);
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed_in == '0) ? SEED_W : seed_in;
    end else if (step_evt) begin
      lfsr_d = {lfsr_q[WIDTH-2:0], fb};
    end else if (lfsr_q == '0) begin
      lfsr_d = SEED_W;
    end
  end

  always_comb begin
    adj = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = scratch_q[4*i +: 4] +
                      ((scratch_q[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    scratch_d   = scratch_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;
    busy_d      = busy_q;
    pending_d   = pending_q;
    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          shreg_d   = lfsr_q;
          scratch_d = '0;
          pending_d = 1'b0;
          busy_d    = 1'b1;
          cnt_d     = '0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        scratch_d = {adj[BW-2:0], shreg_q[WIDTH-1]};
        shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        bcd_d       = scratch_q;
        bcd_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    // A change in this same cycle must survive the IDLE capture clearing pending.
    if (lfsr_d != lfsr_q) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
      pre_q       <= '0;
      lfsr_q      <= SEED_W;
      pending_q   <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      scratch_q   <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= step;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      pre_q       <= pre_d;
      lfsr_q      <= lfsr_d;
      pending_q   <= pending_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      scratch_q   <= scratch_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lfsr_bcd_gen.sv
// Directed bench for lfsr_bcd_gen: scoreboard of expected BCD words checked on
// every bcd_valid, plus directed checks of stepping, load, free-run and reset.
module tb_lfsr_bcd_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        step, run, load;
  logic [6:0]  seed_in;
  logic [6:0]  lfsr;
  logic [19:0] bcd;
  logic        bcd_valid, busy;

  logic        load2;
  logic [11:0] seed2;
  logic [11:0] lfsr2;
  logic [15:0] bcd2;
  logic        bcd_valid2, busy2;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int nvalid = 0;
  bit sb_en  = 1'b1;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lfsr_bcd_gen #(.WIDTH(7), .TAPS('b1100000), .SEED(1), .DIGITS(5), .RATE(4)) dut (
    .clk(clk), .rst_n(rst_n), .step(step), .run(run), .load(load),
    .seed_in(seed_in), .lfsr_q(lfsr), .bcd(bcd), .bcd_valid(bcd_valid), .busy(busy)
  );

  lfsr_bcd_gen #(.WIDTH(12), .TAPS('b111000001000), .SEED(1), .DIGITS(4), .RATE(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .step(1'b0), .run(1'b0), .load(load2),
    .seed_in(seed2), .lfsr_q(lfsr2), .bcd(bcd2), .bcd_valid(bcd_valid2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] nxt(input logic [6:0] x);
    return {x[5:0], x[6] ^ x[5]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_change(input logic [6:0] old, output int at);
    at = -1;
    for (int k = 0; k < 12 && at < 0; k++) begin
      @(negedge clk);
      if (lfsr !== old) at = cyc;
    end
  endtask

  task automatic wait_valid(output int at);
    at = -1;
    for (int k = 0; k < 20 && at < 0; k++) begin
      @(negedge clk);
      if (bcd_valid === 1'b1) at = cyc;
    end
  endtask

  always @(negedge clk) begin
    if (bcd_valid === 1'b1) begin
      nvalid++;
      if (sb_en) begin
        if (exp_q.size() == 0) chk("sb_unexpected_valid", 32'd1, 32'd0);
        else chk("sb_bcd", 32'(bcd), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [6:0] model, prev, start;
    int t_chg, t_val, v0, distinct;
    bit seen[128];

    rst_n = 1'b0; step = 1'b0; run = 1'b0; load = 1'b0; seed_in = '0;
    load2 = 1'b0; seed2 = '0;
    model = 7'd1;
    exp_q.push_back(to_bcd(1));
    tick(3);
    chk("rst_lfsr", 32'(lfsr), 32'd1);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_valid", 32'(bcd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_valid(t_val);
    chk("rst_valid_seen", 32'(t_val >= 0), 32'd1);
    tick(20);
    chk("rst_valid_once", 32'(nvalid), 32'd1);
    chk("rst_lfsr_after", 32'(lfsr), 32'd1);
    chk("rst_busy_after", 32'(busy), 32'd0);

    // Seven key pulses with latency check.
    for (int k = 0; k < 7; k++) begin
      prev  = lfsr;
      model = nxt(model);
      exp_q.push_back(to_bcd(int'(model)));
      step = 1'b1; tick(2); step = 1'b0;
      wait_change(prev, t_chg);
      chk("step_change_seen", 32'(t_chg >= 0), 32'd1);
      chk("step_lfsr", 32'(lfsr), 32'(model));
      wait_valid(t_val);
      chk("step_latency", 32'(t_val - t_chg), 32'd9);
      if (k == 5) chk("step6_bcd", 32'(bcd), 32'h00065);
      tick(20);
    end
    chk("step_seq_end", 32'(lfsr), 32'd3);

    // Long key hold: one advance only.
    model = nxt(model);
    exp_q.push_back(to_bcd(int'(model)));
    step = 1'b1; tick(100); step = 1'b0; tick(20);
    chk("hold_one_adv", 32'(lfsr), 32'(model));

    // Load paths.
    model = 7'd127;
    exp_q.push_back(to_bcd(127));
    seed_in = 7'd127; load = 1'b1; tick(1); load = 1'b0;
    chk("load_127", 32'(lfsr), 32'd127);
    tick(20);
    chk("load_127_bcd", 32'(bcd), 32'h00127);
    model = 7'd1;
    exp_q.push_back(to_bcd(1));
    seed_in = 7'd0; load = 1'b1; tick(1); load = 1'b0;
    chk("load_zero_seed", 32'(lfsr), 32'd1);
    tick(20);
    // step_evt is high in the cycle after the 2nd sampling edge; load overlaps it.
    model = 7'd50;
    exp_q.push_back(to_bcd(50));
    step = 1'b1; tick(2);
    seed_in = 7'd50; load = 1'b1; tick(1); load = 1'b0; step = 1'b0;
    chk("load_beats_step", 32'(lfsr), 32'd50);
    tick(20);
    chk("load_step_no_adv", 32'(lfsr), 32'd50);
    chk("load_step_bcd", 32'(bcd), 32'h00050);

    // Free-run over the full period.
    sb_en = 1'b0;
    start = model;
    for (int i = 0; i < 128; i++) seen[i] = 1'b0;
    distinct = 0;
    run = 1'b1;
    for (int i = 0; i < 127; i++) begin
      prev = lfsr;
      wait_change(prev, t_chg);
      chk("fr_change_seen", 32'(t_chg >= 0), 32'd1);
      model = nxt(model);
      chk("fr_next", 32'(lfsr), 32'(model));
      chk("fr_nonzero", 32'(lfsr != 7'd0), 32'd1);
      if (!seen[lfsr]) distinct++;
      seen[lfsr] = 1'b1;
    end
    run = 1'b0;
    chk("fr_distinct", 32'(distinct), 32'd127);
    chk("fr_return", 32'(lfsr), 32'(start));
    tick(30);
    exp_q.delete();
    sb_en = 1'b1;
    chk("fr_final_bcd", 32'(bcd), 32'(to_bcd(int'(start))));
    chk("fr_idle", 32'(busy), 32'd0);

    // Two events three cycles apart.
    v0 = nvalid;
    prev = lfsr;
    model = nxt(model);
    exp_q.push_back(to_bcd(int'(model)));
    model = nxt(model);
    exp_q.push_back(to_bcd(int'(model)));
    step = 1'b1; tick(1); step = 1'b0; tick(2);
    step = 1'b1; tick(1); step = 1'b0;
    tick(40);
    chk("close_valids", 32'(nvalid - v0), 32'd2);
    chk("close_lfsr", 32'(lfsr), 32'(model));
    chk("close_bcd", 32'(bcd), 32'(to_bcd(int'(model))));

    // Reset during SHIFT.
    prev = lfsr;
    model = nxt(model);
    exp_q.push_back(to_bcd(int'(model)));
    step = 1'b1; tick(2); step = 1'b0;
    wait_change(prev, t_chg);
    tick(3);
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_lfsr", 32'(lfsr), 32'd1);
    chk("mid_rst_bcd", 32'(bcd), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(bcd_valid), 32'd0);
    exp_q.delete();
    model = 7'd1;
    exp_q.push_back(to_bcd(1));
    tick(2);
    v0 = nvalid;
    rst_n = 1'b1;
    tick(25);
    chk("mid_rst_reconv", 32'(nvalid - v0), 32'd1);
    chk("mid_rst_bcd_seed", 32'(bcd), 32'h00001);

    // 12-bit / 4-digit variant.
    seed2 = 12'd4095; load2 = 1'b1; tick(1); load2 = 1'b0;
    chk("w12_lfsr", 32'(lfsr2), 32'd4095);
    tick(25);
    chk("w12_bcd", 32'(bcd2), 32'h4095);
    chk("w12_idle", 32'(busy2), 32'd0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_bcd_gen.md
Name: lfsr_bcd_gen

Overview:
Parametrised pseudo-random number source with an on-chip sequential binary-to-BCD converter. It replaces the key-clocked 7-bit LFSR plus combinational converter pair. It runs entirely on the system clock and advances on a synchronised, edge-detected key or a free-running prescaler. Its packed BCD output feeds the existing per-digit hex_to_7seg decoders.

Parameters:
WIDTH, 7, LFSR width in bits (3..16).
TAPS, 7'b1100000, feedback tap mask (bit i set = q[i] included in XOR); default is x^7+x^6+1.
SEED, 1, reset / lock-up recovery value; must be non-zero.
DIGITS, 5, BCD digits output; must satisfy 10^DIGITS > 2^WIDTH-1.
RATE, 25000000, prescaler period in clk cycles for free-run mode (>=2).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
step  in  1  raw asynchronous step request (e.g. ~KEY[3]); rising edge advances LFSR once
run  in  1  1 = free-run mode, advance every RATE cycles; step ignored
load  in  1  synchronous, 1-cycle: load seed_in into LFSR
seed_in  in  WIDTH  value for load
lfsr_q  out  WIDTH  current LFSR state
bcd  out  4*DIGITS  packed BCD of last converted value, digit 0 = bits[3:0] (units)
bcd_valid  out  1  1-cycle pulse when bcd updates
busy  out  1  converter active

Behaviour:
- Reset (async assert, sync release): lfsr_q=SEED, bcd=0, bcd_valid=0, busy=0, synchroniser/edge flops=0, prescaler=0, pending=1. The BCD of SEED therefore appears automatically after reset.
- Step path: 2-flop synchroniser plus edge register. step_evt = sync_q & ~prev. lfsr_q updates on the 3rd rising clk edge after step is first sampled high. Holding step high gives exactly one advance.
- Free-run: when run=1, prescaler counts 0..RATE-1. step_evt is asserted when count==RATE-1, then the count wraps to 0. When run=0, prescaler is held at 0.
- LFSR (Fibonacci): fb = ^(lfsr_q & TAPS); next = {lfsr_q[WIDTH-2:0], fb}.
- Priority, highest first:
  - load: lfsr_q<=seed_in, or SEED if seed_in==0.
  - step_evt: advance.
  - lfsr_q==0 (lock-up, e.g. after bad TAPS): lfsr_q<=SEED.
  - otherwise hold.
- load and step_evt in the same cycle: load wins and the step is dropped.
- Any lfsr_q change sets pending.
- Converter FSM, states IDLE, SHIFT, DONE:
  - IDLE: if pending, capture lfsr_q into shift reg, clear scratch digits, clear pending, busy=1, counter=0, go to SHIFT.
  - SHIFT: one iteration per cycle. Add 3 to each scratch digit >=5, then shift {scratch, shreg} left by 1. After WIDTH iterations go to DONE.
  - DONE: bcd<=scratch, bcd_valid=1 for this cycle, busy=0, go to IDLE.
- Latency: bcd_valid asserts WIDTH+2 cycles after lfsr_q changes, when the converter is idle.
- LFSR change while busy: conversion continues on its captured value. pending is set, and IDLE restarts immediately with the newest lfsr_q. Intermediate values may be skipped, but the final bcd always matches the final lfsr_q.
- bcd holds its value between updates. Unused upper digits read 0.
- Reset mid-conversion aborts it; the reset values above apply.

Test Plan:
- Reset, defaults, run=0: after release, bcd_valid pulses once with bcd=20'h00001 at cycle 9. lfsr_q=1, busy=0 afterwards.
- Seven step pulses, spaced >=20 cycles: lfsr_q sequence 2,4,8,16,32,65,3. After the 6th step, bcd=20'h00065. Each bcd_valid comes 9 cycles after its lfsr_q change. Holding step high for 100 cycles yields one advance only.
- load seed_in=127: bcd=20'h00127. load seed_in=0: lfsr_q=SEED=1. load and step_evt in the same cycle: lfsr_q=seed_in, no advance.
- Free-run, RATE=4, 127*4 cycles: lfsr_q visits all 127 non-zero states exactly once and returns to the start state. No value is 0.
- Two steps 3 cycles apart: only one bcd_valid for the intermediate value, followed by a conversion whose bcd equals the final lfsr_q.
- Reset asserted mid-SHIFT: outputs go to reset values immediately. A fresh conversion of SEED follows release. WIDTH=12, DIGITS=4 variant with load 4095 gives bcd=16'h4095.
